// File: rtl/seq_pkg.sv
`timescale 1ns/1ps
// Shared types and instruction-field layout for the step sequencer slice.
package seq_pkg;

  typedef enum logic [2:0] {
    DISPLAY = 3'd0,
    LOAD    = 3'd1,
    MOVE    = 3'd2,
    ADD     = 3'd3,
    SUB     = 3'd4,
    ADDI    = 3'd5
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int INSTR_W = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int P1_MSB  = 8;
  localparam int P1_LSB  = 6;
  localparam int P2_MSB  = 5;
  localparam int P2_LSB  = 3;
  localparam int P3_MSB  = 2;
  localparam int P3_LSB  = 0;

  function automatic logic is_legal(input logic [2:0] op);
    case (op)
      DISPLAY, LOAD, MOVE, ADD, SUB, ADDI: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/step_ring.sv
`timescale 1ns/1ps
// One-hot timestep ring: clear beats load beats advance, and the top step saturates.
module step_ring #(
  parameter int STEPS = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             advance,
  output logic [STEPS-1:0] t
);

  // Timestep register; never holds more than one set bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      t <= {STEPS{1'b0}};
    end else if (clear) begin
      t <= {STEPS{1'b0}};
    end else if (load) begin
      t <= {{(STEPS-1){1'b0}}, 1'b1};
    end else if (advance && !t[STEPS-1]) begin
      t <= {t[STEPS-2:0], 1'b0};
    end else begin
      t <= t;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
`timescale 1ns/1ps
// Timestep/done initiator for the function register.
// Optional final-step watchdog enabled by defining STEP_WATCHDOG_EN.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int STEPS = 5,
  parameter int CNT_W = 8
`ifdef STEP_WATCHDOG_EN
  , parameter int TIMEOUT = 4
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               done,
  output logic [STEPS-1:0]   T,
  output logic [2:0]         opcode,
  output logic [2:0]         p1,
  output logic [2:0]         p2,
  output logic [2:0]         p3,
  output logic               busy,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired,
  output logic               timeout_err
);

  state_e     state_r;
  logic [2:0] op_s;
  logic       accept_s;
  logic       finish_s;
  logic       abort_s;
  logic       ring_clear_s;
  logic       ring_advance_s;

  assign op_s           = instr[OP_MSB:OP_LSB];
  assign accept_s       = (state_r == IDLE) && instr_valid && is_legal(op_s);
  assign finish_s       = (state_r == EXEC) && done;
  assign ring_clear_s   = finish_s || abort_s;
  assign ring_advance_s = (state_r == EXEC);

  step_ring #(.STEPS(STEPS)) u_ring (
    .clock   (clock),
    .reset   (reset),
    .clear   (ring_clear_s),
    .load    (accept_s),
    .advance (ring_advance_s),
    .t       (T)
  );

`ifdef STEP_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [WD_W-1:0] wd_cnt_r;

  // Counts cycles parked on the final step while done stays low.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if ((state_r == EXEC) && T[STEPS-1] && !done) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(32'd1);
    end else begin
      wd_cnt_r <= {WD_W{1'b0}};
    end
  end

  assign abort_s = (state_r == EXEC) && T[STEPS-1] && !done && (wd_cnt_r == WD_W'(TIMEOUT));
`else
  assign abort_s = 1'b0;
`endif

  // Control FSM with registered handshake, field latches, pulses and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      retired     <= {CNT_W{1'b0}};
      opcode      <= 3'd0;
      p1          <= 3'd0;
      p2          <= 3'd0;
      p3          <= 3'd0;
    end else begin
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= EXEC;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            opcode      <= op_s;
            p1          <= instr[P1_MSB:P1_LSB];
            p2          <= instr[P2_MSB:P2_LSB];
            p3          <= instr[P3_MSB:P3_LSB];
          end else if (instr_valid) begin
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (finish_s) begin
            state_r     <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            retired     <= retired + CNT_W'(32'd1);
          end else if (abort_s) begin
            state_r     <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for step_sequencer against a step-index reference model.
module tb_step_sequencer;
  localparam int STEPS   = 5;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [11:0]      instr;
  logic             instr_valid;
  logic             done;
  logic             instr_ready;
  logic [STEPS-1:0] T;
  logic [2:0]       opcode, p1, p2, p3;
  logic             busy, illegal, timeout_err;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int failures = 0;

  // Reference model: m_step 0 = idle, k = timestep k-1 active.
  int         m_step, m_ret, m_park;
  logic [2:0] m_op, m_p1, m_p2, m_p3;
  logic       m_ill, m_to;

  step_sequencer dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .T(T), .opcode(opcode),
    .p1(p1), .p2(p2), .p3(p3), .busy(busy), .illegal(illegal),
    .retired(retired), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [STEPS-1:0] exp_t();
    logic [STEPS-1:0] v;
    v = '0;
    if (m_step > 0) v[m_step-1] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_step = 0; m_ret = 0; m_park = 0; m_ill = 1'b0; m_to = 1'b0;
      m_op = 3'd0; m_p1 = 3'd0; m_p2 = 3'd0; m_p3 = 3'd0;
    end else begin
      m_ill = 1'b0; m_to = 1'b0;
      if (m_step == 0) begin
        if (instr_valid) begin
          if (instr[11:9] >= 3'd6) m_ill = 1'b1;
          else begin
            m_step = 1;
            m_op = instr[11:9]; m_p1 = instr[8:6]; m_p2 = instr[5:3]; m_p3 = instr[2:0];
          end
        end
      end else if (done) begin
        m_step = 0; m_park = 0; m_ret = (m_ret + 1) % (1 << CNT_W);
      end else if (m_step < STEPS) begin
        m_step++; m_park = 0;
      end else begin
        m_park++;
`ifdef STEP_WATCHDOG_EN
        if (m_park > TIMEOUT) begin m_step = 0; m_park = 0; m_to = 1'b1; end
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; done = 1'b0; instr = 12'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b1; done = 1'b1; instr = 12'b011_001_010_011;
    tick(); tick();
    reset = 1'b0; instr_valid = 1'b0; done = 1'b0;
    checks++; if (T !== 5'b00000) begin failures++; $display("FAIL reset_T got=%b exp=00000", T); end
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    checks++; if ({busy, illegal, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, illegal, timeout_err}); end
    checks++; if (retired !== 8'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    checks++; if ({opcode, p1, p2, p3} !== 12'd0) begin failures++; $display("FAIL reset_fields got=%h exp=000", {opcode, p1, p2, p3}); end
  endtask

  task automatic test_load();
    logic [STEPS-1:0] seq [3];
    int low;
    seq = '{5'b00001, 5'b00010, 5'b00000};
    low = 0;
    do_reset();
    instr = 12'b001_011_000_000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (T !== seq[i]) begin failures++; $display("FAIL load_T step%0d got=%b exp=%b", i, T, seq[i]); end
      if (!instr_ready) low++;
      done = (m_step == 2);
      tick();
    end
    done = 1'b0;
    checks++; if (low !== 2) begin failures++; $display("FAIL load_ready_low got=%0d exp=2", low); end
    checks++; if (retired !== 8'd1) begin failures++; $display("FAIL load_retired got=%0d exp=1", retired); end
    checks++; if ({opcode, p1} !== 6'b001_011) begin failures++; $display("FAIL load_fields got=%b exp=001011", {opcode, p1}); end
  endtask

  task automatic test_add();
    logic [STEPS-1:0] seq [5];
    seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00000};
    do_reset();
    instr = 12'b011_001_010_011; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (T !== seq[i]) begin failures++; $display("FAIL add_T step%0d got=%b exp=%b", i, T, seq[i]); end
      checks++; if ({opcode, p1, p2, p3} !== 12'b011_001_010_011) begin failures++; $display("FAIL add_fields step%0d got=%b exp=011001010011", i, {opcode, p1, p2, p3}); end
      done = (m_step == 4);
      tick();
    end
    done = 1'b0;
    checks++; if (retired !== 8'd1) begin failures++; $display("FAIL add_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      instr = {((k % 2 == 0) ? 3'b110 : 3'b111), 9'($urandom)};
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      checks++; if ({illegal, instr_ready, T} !== {1'b1, 1'b1, 5'b00000}) begin failures++; $display("FAIL illegal_pulse k%0d got=%b exp=1100000", k, {illegal, instr_ready, T}); end
      tick();
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_once k%0d got=%b exp=0", k, illegal); end
    end
    checks++; if (retired !== 8'd0) begin failures++; $display("FAIL illegal_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    instr = {3'b011, 9'($urandom)}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 8 && m_step != 3; i++) tick();
    checks++; if (T !== 5'b00100) begin failures++; $display("FAIL midreset_pre_T got=%b exp=00100", T); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (T !== 5'b00000) begin failures++; $display("FAIL midreset_T got=%b exp=00000", T); end
    checks++; if ({opcode, p1, p2, p3} !== 12'd0) begin failures++; $display("FAIL midreset_fields got=%h exp=000", {opcode, p1, p2, p3}); end
    checks++; if ({instr_ready, busy, retired} !== {1'b1, 1'b0, 8'd0}) begin failures++; $display("FAIL midreset_state got=%b exp=1000000000", {instr_ready, busy, retired}); end
  endtask

  task automatic test_no_done();
    int parked, pulses;
    parked = 0; pulses = 0;
    do_reset();
    instr = {3'b100, 9'($urandom)}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checks++; if (T !== exp_t()) begin failures++; $display("FAIL nodone_T cyc%0d got=%b exp=%b", i, T, exp_t()); end
      checks++; if ({timeout_err, busy} !== {m_to, m_step != 0}) begin failures++; $display("FAIL nodone_flags cyc%0d got=%b exp=%b", i, {timeout_err, busy}, {m_to, m_step != 0}); end
      if (T === 5'b10000) parked++;
      if (timeout_err === 1'b1) pulses++;
      tick();
    end
`ifdef STEP_WATCHDOG_EN
    checks++; if (parked !== TIMEOUT + 1 || pulses !== 1) begin failures++; $display("FAIL nodone_watchdog parked=%0d pulses=%0d exp=%0d,1", parked, pulses, TIMEOUT + 1); end
`else
    checks++; if (parked < 20 || pulses !== 0) begin failures++; $display("FAIL nodone_hold parked=%0d pulses=%0d exp>=20,0", parked, pulses); end
`endif
    checks++; if (retired !== 8'd0) begin failures++; $display("FAIL nodone_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      instr_valid = ($urandom_range(0, 9) < 7);
      instr = 12'($urandom);
      done = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (T !== exp_t()) begin failures++; $display("FAIL rand_T cyc%0d got=%b exp=%b", i, T, exp_t()); end
      checks++; if ({instr_ready, busy, illegal, timeout_err} !== {m_step == 0, m_step != 0, m_ill, m_to}) begin failures++; $display("FAIL rand_flags cyc%0d got=%b exp=%b", i, {instr_ready, busy, illegal, timeout_err}, {m_step == 0, m_step != 0, m_ill, m_to}); end
      checks++; if ({opcode, p1, p2, p3} !== {m_op, m_p1, m_p2, m_p3}) begin failures++; $display("FAIL rand_fields cyc%0d got=%h exp=%h", i, {opcode, p1, p2, p3}, {m_op, m_p1, m_p2, m_p3}); end
      checks++; if (retired !== CNT_W'(m_ret)) begin failures++; $display("FAIL rand_retired cyc%0d got=%0d exp=%0d", i, retired, m_ret); end
    end
    done = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n_ret, cycles;
    n_ret = 0; cycles = 0;
    do_reset();
    instr = {3'b010, 9'($urandom)}; instr_valid = 1'b1;
    while (n_ret < 256 && cycles < 1000) begin
      done = (m_step == 2);
      if (done) n_ret++;
      tick();
      cycles++;
      checks++; if ({T, busy, instr_ready} !== {exp_t(), m_step != 0, m_step == 0}) begin failures++; $display("FAIL b2b_state cyc%0d got=%b exp=%b", cycles, {T, busy, instr_ready}, {exp_t(), m_step != 0, m_step == 0}); end
    end
    instr_valid = 1'b0; done = 1'b0;
    checks++; if (cycles !== 768) begin failures++; $display("FAIL b2b_cycles got=%0d exp=768", cycles); end
    checks++; if (retired !== 8'd0) begin failures++; $display("FAIL b2b_wrap got=%0d exp=0", retired); end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; done = 1'b0; instr = 12'd0;
    m_step = 0; m_ret = 0; m_park = 0; m_ill = 1'b0; m_to = 1'b0;
    m_op = 3'd0; m_p1 = 3'd0; m_p2 = 3'd0; m_p3 = 3'd0;
    @(negedge clock);
    test_reset();
    test_load();
    test_add();
    test_illegal();
    test_reset_mid_exec();
    test_no_done();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
